// File: rtl/risco5_bridge_pkg.sv
// Shared types and helpers for the Risco_5 core to uio pin-bank memory bridge.
// Frame layout: command beat, address beats, then write data or turnaround plus read data.
package risco5_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    TURN,
    RDATA,
    DONE
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  function automatic int unsigned beat_count(input int unsigned field_w, input int unsigned bus_w);
    return field_w / bus_w;
  endfunction

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uio_beat_shifter.sv
// Beat shift register: loads {address, write data}, presents the MSB beat, and
// shifts read beats in at the bottom so the low TAIL_W bits end up holding the read word.
module uio_beat_shifter #(
  parameter int unsigned WORD_W = 56,
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned TAIL_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_load_word,
  input  logic              i_shift_out,
  input  logic              i_shift_in,
  input  logic [BEAT_W-1:0] i_beat,
  output logic [BEAT_W-1:0] o_beat,
  output logic [TAIL_W-1:0] o_tail
);

  logic [WORD_W-1:0] r_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_load_word;
    end else if (i_shift_out) begin
      r_word <= {r_word[WORD_W-BEAT_W-1:0], {BEAT_W{1'b0}}};
    end else if (i_shift_in) begin
      r_word <= {r_word[WORD_W-BEAT_W-1:0], i_beat};
    end
  end

  assign o_beat = r_word[WORD_W-1 -: BEAT_W];
  assign o_tail = r_word[TAIL_W-1:0];

endmodule

// File: rtl/uio_mem_bridge.sv
// Serialises core memory accesses into strobe/ready beat frames on the uio pins,
// turns the bus around for reads, and reports a per-beat wait timeout as mem_err.
module uio_mem_bridge
  import risco5_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ack,
  output logic                  mem_err,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [BUS_WIDTH-1:0]  bus_oe,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  output logic                  ext_strobe,
  input  logic                  ext_ready
);

  localparam int unsigned AB   = beat_count(ADDR_WIDTH, BUS_WIDTH);
  localparam int unsigned DB   = beat_count(DATA_WIDTH, BUS_WIDTH);
  localparam int unsigned BC_W = count_width(((AB > DB) ? AB : DB) - 1);
  localparam int unsigned WC_W = count_width((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(AB - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DB - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_is_wr;
  logic              r_err;
  logic [BC_W-1:0]   r_beat;
  logic [WC_W-1:0]   r_wait;

  logic              w_req;
  logic              w_strobe;
  logic              w_drive;
  logic              w_beat_done;
  logic              w_timeout;
  logic              w_load;
  logic              w_shift_out;
  logic              w_shift_in;
  logic [BUS_WIDTH-1:0]  w_shift_beat;
  logic [BUS_WIDTH-1:0]  w_cmd_beat;
  logic [DATA_WIDTH-1:0] w_read_word;

  assign w_req       = mem_wr || mem_rd;
  assign w_drive     = (r_state == CMD) || (r_state == ADDR) || (r_state == WDATA);
  assign w_strobe    = w_drive || (r_state == RDATA);
  assign w_beat_done = w_strobe && ext_ready;
  assign w_timeout   = (TIMEOUT != 0) && w_strobe && !ext_ready && (r_wait == WAIT_LAST);
  assign w_load      = (r_state == IDLE) && w_req;
  assign w_shift_out = w_beat_done && ((r_state == ADDR) || (r_state == WDATA));
  assign w_shift_in  = w_beat_done && (r_state == RDATA);

  // Address and write data travel as one word so the frame order falls out of a single MSB-first shift.
  uio_beat_shifter #(
    .WORD_W(ADDR_WIDTH + DATA_WIDTH),
    .BEAT_W(BUS_WIDTH),
    .TAIL_W(DATA_WIDTH)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_word ({mem_addr, mem_wdata}),
    .i_shift_out (w_shift_out),
    .i_shift_in  (w_shift_in),
    .i_beat      (bus_in),
    .o_beat      (w_shift_beat),
    .o_tail      (w_read_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_is_wr <= 1'b0;
      r_err   <= 1'b0;
      r_beat  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        r_is_wr <= mem_wr;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_next_state != r_state) begin
        r_beat <= '0;
      end else if (w_beat_done) begin
        r_beat <= r_beat + BC_W'(1);
      end
      if (w_beat_done || !w_strobe) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + WC_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_req) w_next_state = CMD;
      CMD:   if (w_beat_done) w_next_state = ADDR;
      ADDR:  if (w_beat_done && (r_beat == ADDR_LAST)) w_next_state = r_is_wr ? WDATA : TURN;
      WDATA: if (w_beat_done && (r_beat == DATA_LAST)) w_next_state = DONE;
      TURN:  w_next_state = RDATA;
      RDATA: if (w_beat_done && (r_beat == DATA_LAST)) w_next_state = DONE;
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (w_timeout) w_next_state = DONE;
  end

  // Outputs are forced quiet in any reset cycle, not just after reset takes effect.
  always_comb begin
    w_cmd_beat    = '0;
    w_cmd_beat[0] = r_is_wr ? CMD_WRITE : CMD_READ;
    bus_out       = '0;
    bus_oe        = '0;
    ext_strobe    = 1'b0;
    mem_ack       = 1'b0;
    mem_err       = 1'b0;
    mem_rdata     = '0;
    if (!reset) begin
      ext_strobe = w_strobe;
      if (w_drive) begin
        bus_oe  = '1;
        bus_out = (r_state == CMD) ? w_cmd_beat : w_shift_beat;
      end
      if (r_state == DONE) begin
        mem_ack = 1'b1;
        mem_err = r_err;
        if (!r_err && !r_is_wr) mem_rdata = w_read_word;
      end
    end
  end

endmodule

// File: tb/tb_uio_mem_bridge.sv
// Directed bench for uio_mem_bridge: a per-cycle vector table for whole frames plus
// hand sequences for stall, timeout and mid-frame reset.
module tb_uio_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_rd, mem_wr;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  bus_in;
  logic        ext_ready;
  logic [31:0] mem_rdata;
  logic        mem_ack, mem_err;
  logic [7:0]  bus_out, bus_oe;
  logic        ext_strobe;

  logic        to_rd, to_wr, to_ready;
  logic [31:0] to_rdata;
  logic        to_ack, to_err;
  logic [7:0]  to_bus_out, to_bus_oe;
  logic        to_strobe;

  uio_mem_bridge dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .ext_strobe(ext_strobe), .ext_ready(ext_ready)
  );

  uio_mem_bridge #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .mem_rd(to_rd), .mem_wr(to_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(to_rdata),
    .mem_ack(to_ack), .mem_err(to_err), .bus_out(to_bus_out), .bus_oe(to_bus_oe),
    .bus_in(bus_in), .ext_strobe(to_strobe), .ext_ready(to_ready)
  );

  typedef struct {
    logic        rd, wr, rdy;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [7:0]  bin;
    logic [7:0]  out, oe;
    logic        stb, ack, err;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs[$];
  logic        hold_rd, hold_wr;
  logic [23:0] cur_addr;
  logic [31:0] cur_wdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void p(logic rd, logic wr, logic [7:0] bin, logic [7:0] out,
                            logic [7:0] oe, logic stb, logic ack, logic [31:0] rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rdy = 1'b1; v.addr = cur_addr; v.wdata = cur_wdata;
    v.bin = bin; v.out = out; v.oe = oe; v.stb = stb; v.ack = ack; v.err = 1'b0;
    v.rdata = rdata;
    vecs.push_back(v);
  endfunction

  function automatic void idle(logic rd, logic wr);
    p(rd, wr, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 32'h0);
  endfunction
  function automatic void drv(logic [7:0] beat);
    p(hold_rd, hold_wr, 8'h00, beat, 8'hFF, 1'b1, 1'b0, 32'h0);
  endfunction
  function automatic void turn();
    p(hold_rd, hold_wr, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 32'h0);
  endfunction
  function automatic void rbeat(logic [7:0] bin);
    p(hold_rd, hold_wr, bin, 8'h00, 8'h00, 1'b1, 1'b0, 32'h0);
  endfunction
  function automatic void ack(logic [31:0] rdata);
    p(hold_rd, hold_wr, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, rdata);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " bus_out"}, {24'h0, bus_out}, 32'h0);
    chk({tag, " bus_oe"},  {24'h0, bus_oe},  32'h0);
    chk({tag, " strobe"},  {31'h0, ext_strobe}, 32'h0);
    chk({tag, " ack"},     {31'h0, mem_ack}, 32'h0);
    chk({tag, " err"},     {31'h0, mem_err}, 32'h0);
    chk({tag, " rdata"},   mem_rdata, 32'h0);
  endtask

  initial begin
    reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    bus_in = '0; ext_ready = 1'b1; to_rd = 1'b0; to_wr = 1'b0; to_ready = 1'b1;
    hold_rd = 1'b0; hold_wr = 1'b0;

    tick();
    chk_quiet("reset");
    tick();
    reset = 1'b0;
    #1;
    chk_quiet("post_reset");

    // Write frame, ready high
    cur_addr = 24'h123456; cur_wdata = 32'hDEADBEEF;
    idle(1'b0, 1'b1);
    drv(8'h01); drv(8'h12); drv(8'h34); drv(8'h56);
    drv(8'hDE); drv(8'hAD); drv(8'hBE); drv(8'hEF);
    ack(32'h0); idle(1'b0, 1'b0);
    // Read frame
    cur_addr = 24'h00ABCD;
    idle(1'b1, 1'b0);
    drv(8'h00); drv(8'h00); drv(8'hAB); drv(8'hCD); turn();
    rbeat(8'hCA); rbeat(8'hFE); rbeat(8'hBA); rbeat(8'hBE);
    ack(32'hCAFEBABE); idle(1'b0, 1'b0);
    // rd and wr together, held through DONE: write frame, then a second one after one IDLE cycle
    cur_addr = 24'h000001; cur_wdata = 32'h11223344; hold_rd = 1'b1; hold_wr = 1'b1;
    idle(1'b1, 1'b1);
    drv(8'h01); drv(8'h00); drv(8'h00); drv(8'h01);
    drv(8'h11); drv(8'h22); drv(8'h33); drv(8'h44); ack(32'h0);
    idle(1'b1, 1'b1);
    hold_rd = 1'b0; hold_wr = 1'b0;
    drv(8'h01); drv(8'h00); drv(8'h00); drv(8'h01);
    drv(8'h11); drv(8'h22); drv(8'h33); drv(8'h44); ack(32'h0);
    idle(1'b0, 1'b0);

    foreach (vecs[i]) begin
      mem_rd = vecs[i].rd; mem_wr = vecs[i].wr; ext_ready = vecs[i].rdy;
      mem_addr = vecs[i].addr; mem_wdata = vecs[i].wdata; bus_in = vecs[i].bin;
      #1;
      chk($sformatf("v%0d bus_out", i), {24'h0, bus_out}, {24'h0, vecs[i].out});
      chk($sformatf("v%0d bus_oe", i),  {24'h0, bus_oe},  {24'h0, vecs[i].oe});
      chk($sformatf("v%0d strobe", i),  {31'h0, ext_strobe}, {31'h0, vecs[i].stb});
      chk($sformatf("v%0d ack", i),     {31'h0, mem_ack}, {31'h0, vecs[i].ack});
      chk($sformatf("v%0d err", i),     {31'h0, mem_err}, {31'h0, vecs[i].err});
      if (vecs[i].ack) begin
        chk($sformatf("v%0d rdata", i), mem_rdata, vecs[i].rdata);
        $display("[TB] vector frame ending at %0d: ack rdata=%h err=%b", i, mem_rdata, mem_err);
      end
      tick();
    end

    // Read with ready low for 3 cycles on the second address beat
    mem_addr = 24'h00ABCD; mem_wdata = 32'h0; mem_rd = 1'b1; ext_ready = 1'b1;
    tick();
    mem_rd = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      ext_ready = !(c >= 3 && c <= 5);
      case (c)
        9:  bus_in = 8'h01;
        10: bus_in = 8'h23;
        11: bus_in = 8'h45;
        12: bus_in = 8'h67;
        default: bus_in = 8'h00;
      endcase
      #1;
      if (c >= 3 && c <= 6) chk($sformatf("stall c%0d bus_out", c), {24'h0, bus_out}, 32'hAB);
      if (c == 7) chk("stall c7 bus_out", {24'h0, bus_out}, 32'hCD);
      if (c == 8) chk("stall c8 turn oe", {24'h0, bus_oe}, 32'h0);
      chk($sformatf("stall c%0d ack", c), {31'h0, mem_ack}, {31'h0, (c == 13)});
      if (c == 13) chk("stall rdata", mem_rdata, 32'h01234567);
      tick();
    end
    $display("[TB] stalled read done");

    // Timeout instance: ready never high
    mem_wdata = 32'hFFFFFFFF; to_rd = 1'b1; to_ready = 1'b0;
    #1;
    chk("to c0 strobe", {31'h0, to_strobe}, 32'h0);
    tick();
    to_rd = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk($sformatf("to c%0d strobe", c), {31'h0, to_strobe}, {31'h0, (c <= 4)});
      chk($sformatf("to c%0d ack", c), {31'h0, to_ack}, {31'h0, (c == 5)});
      chk($sformatf("to c%0d err", c), {31'h0, to_err}, {31'h0, (c == 5)});
      if (c == 5) begin
        chk("to rdata", to_rdata, 32'h0);
        chk("to bus_oe", {24'h0, to_bus_oe}, 32'h0);
      end
      tick();
    end
    to_ready = 1'b1;
    $display("[TB] timeout read done");

    // Reset during the WDATA phase
    mem_addr = 24'h123456; mem_wdata = 32'hDEADBEEF; mem_wr = 1'b1; ext_ready = 1'b1;
    tick();
    mem_wr = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    chk("rst c6 bus_out", {24'h0, bus_out}, 32'hAD);
    reset = 1'b1;
    #1;
    chk_quiet("rst during");
    tick();
    reset = 1'b0;
    for (int c = 7; c <= 12; c++) begin
      #1;
      chk_quiet($sformatf("rst c%0d", c));
      tick();
    end
    $display("[TB] reset abort done");

    mem_addr = 24'h00ABCD; mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      case (c)
        6: bus_in = 8'h5A;
        7: bus_in = 8'h5A;
        8: bus_in = 8'hA5;
        9: bus_in = 8'hA5;
        default: bus_in = 8'h00;
      endcase
      #1;
      if (c == 5) chk("post c5 bus_oe", {24'h0, bus_oe}, 32'h0);
      chk($sformatf("post c%0d ack", c), {31'h0, mem_ack}, {31'h0, (c == 10)});
      if (c == 10) chk("post rdata", mem_rdata, 32'h5A5AA5A5);
      tick();
    end
    $display("[TB] read after reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uio_mem_bridge.md
Name: uio_mem_bridge

Overview:
- Parametrised memory-bus bridge between the Risco_5 core's word-wide memory port and the narrow TinyTapeout bidirectional pin bank (uio).
- Serialises each core access into a command/address/data beat frame with a per-beat strobe/ready handshake.
- Turns the bus around for reads and reports timeouts back to the core.
- Successor to the fixed 8-pin wiring in the top level: generalised in address, data and pin width.

Parameters:
ADDR_WIDTH, 24, core address bits sent per access; must be a multiple of BUS_WIDTH
DATA_WIDTH, 32, core data word width; must be a multiple of BUS_WIDTH
BUS_WIDTH, 8, external pin-bus width per beat
TIMEOUT, 255, max cycles waiting for ext_ready on one beat; 0 disables timeout

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
mem_rd  input  1  core read request, sampled only in IDLE
mem_wr  input  1  core write request, sampled only in IDLE; wins over mem_rd if both high
mem_addr  input  ADDR_WIDTH  access address, captured with request
mem_wdata  input  DATA_WIDTH  write data, captured with request
mem_rdata  output  DATA_WIDTH  read data, valid while mem_ack=1
mem_ack  output  1  one-cycle completion pulse
mem_err  output  1  one-cycle pulse coincident with mem_ack on timeout
bus_out  output  BUS_WIDTH  beat value driven to pins
bus_oe  output  BUS_WIDTH  pin direction, all-ones = drive, all-zeros = input
bus_in  input  BUS_WIDTH  pin input path for read beats
ext_strobe  output  1  beat offered / requested
ext_ready  input  1  peripheral accepts/provides beat; a beat completes on a cycle with ext_strobe&&ext_ready

Behaviour:
- Reset, or any cycle with reset=1: state IDLE; bus_out=0, bus_oe=0, ext_strobe=0, mem_ack=0, mem_err=0, mem_rdata=0, counters cleared. Reset mid-frame aborts the frame with no ack.
- Beat counts: AB=ADDR_WIDTH/BUS_WIDTH, DB=DATA_WIDTH/BUS_WIDTH (defaults 3 and 4). All multi-beat fields are sent MSB beat first.
- Command beat: bit0=1 for write, 0 for read; all other bits 0.
- States and transitions:
  - IDLE: if mem_wr or mem_rd, latch the request, address and data, then go to CMD.
  - CMD: one beat; next ADDR.
  - ADDR: AB beats; on the last beat go to WDATA (write) or TURN (read).
  - WDATA: DB beats; next DONE.
  - TURN: exactly one cycle; bus_oe=0, strobe=0; next RDATA.
  - RDATA: DB beats; bus_in is shifted in on each completed beat; next DONE.
  - DONE: one cycle; mem_ack=1, mem_rdata holds the assembled word (0 for writes and errors); next IDLE.
- bus_oe is all-ones in CMD/ADDR/WDATA and all-zeros elsewhere. ext_strobe=1 in CMD/ADDR/WDATA/RDATA.
- bus_out holds a stable beat until it is accepted. Outside drive states bus_out=0.
- Core inputs are ignored outside IDLE; the core may drop its request after the capture cycle. A request still held after DONE starts a new frame only after the mandatory IDLE cycle.
- Latency with ext_ready tied high, request seen at cycle 0:
  - write: beats on cycles 1..8, mem_ack on cycle 9;
  - read: CMD+ADDR on cycles 1..4, TURN on 5, RDATA on 6..9, mem_ack on 10.
  - Each stalled cycle (ready low) adds one cycle.
- Timeout: a per-beat wait counter increments each cycle with strobe&&!ready and clears on each completed beat. When it reaches TIMEOUT: abort to DONE with mem_err=1, mem_rdata=0, bus_oe=0.
- ext_ready outside strobe cycles is ignored.

Decomposition:
- Package risco5_bridge_pkg holds:
  - state enum (IDLE, CMD, ADDR, WDATA, TURN, RDATA, DONE);
  - CMD_READ/CMD_WRITE constants;
  - beat-count helper functions.
- Sub-module uio_beat_shifter (parametrised width/beat size): loads a word, shifts out MSB beats, and shifts in read beats. The FSM, counters and timeout stay in uio_mem_bridge.

Test Plan:
- Write, addr=0x123456, wdata=0xDEADBEEF, ready high -> bus_out beats 0x01,0x12,0x34,0x56,0xDE,0xAD,0xBE,0xEF on cycles 1..8 with bus_oe=0xFF; mem_ack=1, mem_err=0 on cycle 9.
- Read, addr=0x00ABCD; peripheral returns 0xCA,0xFE,0xBA,0xBE -> beats 0x00,0x00,0xAB,0xCD; bus_oe=0x00 from cycle 5; mem_rdata=0xCAFEBABE with mem_ack on cycle 10.
- mem_rd and mem_wr high together -> command beat 0x01 (write frame).
- Read with ext_ready low for 3 cycles on the second address beat -> same bus_out held throughout the stall; mem_ack on cycle 13.
- TIMEOUT=4 with ext_ready never high -> strobe for 4 cycles, then DONE with mem_ack=mem_err=1, mem_rdata=0, then IDLE.
- reset pulsed during the WDATA beat -> next cycle all outputs 0 and no ack; a following read completes normally.
